// File: rtl/spm_stream.sv
// -----------------------------------------------------------------------------
// spm_stream -- streaming serial-parallel multiplier
//
// Purpose:
//   Accepts an operand pair (a, x) over a valid/ready handshake. It consumes
//   x one bit per clock, LSB first, with a shift-add datapath. It then presents
//   the full 2*WIDTH product over a valid/ready output handshake. Unsigned and
//   two's-complement operation are selected per transaction with signed_mode.
//
// Parameters:
//   WIDTH        operand width in bits (2..64); the product is 2*WIDTH bits.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (priority over all inputs)
//   in_valid     operand pair valid
//   in_ready     block can accept operands (high only in IDLE)
//   signed_mode  0 = unsigned x unsigned, 1 = signed x signed (sampled at accept)
//   a            multiplicand (sampled at accept)
//   x            multiplier, consumed LSB first (sampled at accept)
//   out_valid    product valid (high only in DONE)
//   out_ready    downstream accepts the product
//   y            registered product; updated only on entry to DONE
//   busy         high while bits of x are being processed
//
// Build option:
//   SPM_STREAM_EARLY_EXIT_EN  when defined, BUSY ends after the edge that
//                             processes the most significant 1 of x. At least
//                             one BUSY edge always occurs. Product values are
//                             unchanged. When undefined, latency is always
//                             WIDTH edges.
// -----------------------------------------------------------------------------
module spm_stream #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     x,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Operand/accumulator registers
    logic signed [PW-1:0]   r_a;        // extended multiplicand, pre-shifted by k
    logic        [WIDTH-1:0] r_x;       // multiplier, shifted so bit k sits at [0]
    logic                   r_signed;
    logic signed [PW-1:0]   r_acc;
    logic        [CW-1:0]   r_cnt;      // index k of the bit being processed
    logic        [PW-1:0]   r_y;

    logic                   w_accept;
    logic                   w_msb_step;
    logic                   w_last_bit;
    logic signed [PW-1:0]   w_addend;
    logic signed [PW-1:0]   w_acc_nxt;

    // Extend an operand to product width: zero-extend for unsigned,
    // sign-extend for two's-complement.
    function automatic logic signed [PW-1:0] ext_operand(
        input logic [WIDTH-1:0] v,
        input logic             is_signed
    );
        logic fill;
        fill        = is_signed & v[WIDTH-1];
        ext_operand = {{WIDTH{fill}}, v};
    endfunction

    // One shift-add step. In signed mode the MSB of x carries weight
    // -2^(WIDTH-1), so the last partial product is subtracted, not added.
    function automatic logic signed [PW-1:0] acc_step(
        input logic signed [PW-1:0] acc,
        input logic signed [PW-1:0] addend,
        input logic                 subtract
    );
        acc_step = subtract ? (acc - addend) : (acc + addend);
    endfunction

    // ------------------------------------------------------------------
    // Bit-step control
    // ------------------------------------------------------------------
    assign w_msb_step = (r_cnt == CNT_LAST);

`ifdef SPM_STREAM_EARLY_EXIT_EN
    // r_x has already been shifted so bit k is at [0]. When every bit above
    // it is zero, no later step can change the accumulator, so this is the
    // last step. A negative signed x keeps its MSB set and runs all WIDTH
    // steps. That preserves the subtract on the final step.
    assign w_last_bit = w_msb_step || (r_x[WIDTH-1:1] == '0);
`else
    assign w_last_bit = w_msb_step;
`endif

    assign w_addend  = r_x[0] ? r_a : '0;
    assign w_acc_nxt = acc_step(r_acc, w_addend, r_signed & w_msb_step);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                busy = 1'b1;
                if (w_last_bit) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                // Return to IDLE for one cycle; no accept overlaps this handshake.
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-add datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_x      <= '0;
            r_signed <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_y      <= '0;
        end else if (w_accept) begin
            r_a      <= ext_operand(a, signed_mode);
            r_x      <= x;
            r_signed <= signed_mode;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_BUSY) begin
            // Shifting a left and x right each step avoids a barrel
            // shifter indexed by k.
            r_acc <= w_acc_nxt;
            r_a   <= r_a <<< 1;
            r_x   <= r_x >> 1;
            r_cnt <= r_cnt + 1'b1;
            if (w_last_bit) begin
                r_y <= w_acc_nxt;
            end
        end
    end

    assign y = r_y;

endmodule
